seq_detect_moore: RTL

Parametrised Moore-style serial pattern detector; generalises the fixed single-bit detector used in the packet processor front end. Compares a gated serial bit stream against a run-time-loadable pattern of PAT_LEN bits, with selectable overlapping/non-overlapping detection and a saturating match counter. Sits between the bit-level receive logic and the packet-processor control FSM, flagging sync/marker sequences.

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/seq_detect_moore_sat_counter.sv | 44 ++++
 rtl/seq_detect_moore.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------
// seq_detect_pkg : shared types and limits for the serial pattern detector
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package seq_detect_pkg;

  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MAX   = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2,
    MATCH   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_detect_moore_sat_counter.sv
// ---------------------------------------------------------------
// sat_counter : W-bit up counter that sticks at all ones; clear wins over hold
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign sat   = &count_q;
  assign count = count_q;

  // A clear coinciding with an increment leaves the new event counted.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && !sat) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_moore.sv
// ---------------------------------------------------------------
// seq_detect_moore : Moore serial pattern detector with saturating match count.
// Optional SEQ_DETECT_MASK_EN adds a per-bit don't-care mask. Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic               i,
  input  logic [PAT_LEN-1:0] pattern,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask,
`endif
  input  logic               pat_load,
  input  logic               overlap,
  input  logic               clear,
  output logic               o,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               o_q, o_d;
  logic [PAT_LEN-1:0] cmp_mask;
  logic [PAT_LEN-1:0] hist_next;
  logic [FW-1:0]      fill_next;
  logic               hit;
  logic               inc;

`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_LEN-1:0] mask_q, mask_d;
  assign cmp_mask = mask_q;
  always_comb begin
    mask_d = mask_q;
    if (pat_load) mask_d = pat_mask;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) mask_q <= '1;
    else        mask_q <= mask_d;
  end
`else
  assign cmp_mask = '1;
`endif

  // Match is judged on the post-shift history so o rises on the completing edge.
  always_comb begin
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    inc       = 1'b0;
    hist_next = {hist_q[PAT_LEN-2:0], i};
    fill_next = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    hit       = (fill_next == FULL) && (((hist_next ^ pat_q) & cmp_mask) == '0);
    if (pat_load) begin
      pat_d   = pattern;
      hist_d  = '0;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (en) begin
      hist_d = hist_next;
      fill_d = fill_next;
      inc    = hit;
      if (hit) begin
        state_d = MATCH;
        if (!overlap) fill_d = '0;
      end else if (fill_next == FULL) begin
        state_d = ARMED;
      end else begin
        state_d = FILLING;
      end
    end
    o_d = (state_d == MATCH);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      o_q     <= o_d;
    end
  end

  assign o = o_q;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (inc),
    .clr   (clear),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

`default_nettype wire
